cpu_run_ctrl: RTL

Run/step sequencer for the pipelined RISC-V core on the board. Sits between the board buttons and the CPU clock-enable. It debounces the step and run buttons and holds the core paused after reset. It issues single-step or free-run enable windows and stops the core when the program finishes or, optionally, when PC hits a breakpoint.

---
 rtl/cpu_dbg_pkg.sv | 17 +
 rtl/btn_debounce.sv | 48 ++++
 rtl/cpu_run_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// Purpose: shared types for the run/step debug controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: ctrl_state_t (3-bit run-controller state encodings), STATE_W.
package cpu_dbg_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT  = 3'd0,
    ST_PAUSE = 3'd1,
    ST_STEP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Purpose: 2-FF synchronizer plus stability filter for one raw push button.
// Latency: raw edge to press pulse = 2 sync cycles + DEBOUNCE_CYCLES.
// Backpressure: none; free-running level filter, press is a one-cycle pulse.
// Ports: CLK, RST (sync, active-high), raw (async button), level (debounced),
//        press (one cycle on each accepted 0->1 level change).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive cycles the synchronized input disagrees with the
  // accepted level; any agreement restarts the count, so glitches die out.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
        press <= sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Purpose: run/step sequencer driving the CPU clock-enable and core reset.
// Latency: button press acts on the edge after its debounced pulse; finish stops on the next edge.
// Backpressure: none; button pulses outside PAUSE/RUN are dropped.
// Optional feature: `define CPU_BREAKPOINT_EN builds the PC breakpoint comparator.
// Ports: CLK, RST (sync, active-high), btn_step/btn_run (raw buttons), pc, finish,
//        bp_addr/bp_valid (breakpoint), cpu_rst/cpu_en (to core), state, bp_hit,
//        step_count, en_cycles (statistics).
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_CYCLES     = 1,
  parameter int RESET_HOLD      = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                btn_step,
  input  logic                btn_run,
  input  logic [31:0]         pc,
  input  logic                finish,
  input  logic [31:0]         bp_addr,
  input  logic                bp_valid,
  output logic                cpu_rst,
  output logic                cpu_en,
  output logic [STATE_W-1:0]  state,
  output logic                bp_hit,
  output logic [15:0]         step_count,
  output logic [31:0]         en_cycles
);

  localparam int                HOLD_W    = $clog2(RESET_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [7:0]        STEP_LOAD = 8'(STEP_CYCLES);

  ctrl_state_t       state_q;
  ctrl_state_t       state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [7:0]        step_left;
  logic              step_press;
  logic              run_press;
  logic              step_lvl_unused;
  logic              run_lvl_unused;
  logic              bp_stop;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .CLK   (CLK),
    .RST   (RST),
    .raw   (btn_step),
    .level (step_lvl_unused),
    .press (step_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .CLK   (CLK),
    .RST   (RST),
    .raw   (btn_run),
    .level (run_lvl_unused),
    .press (run_press)
  );

`ifdef CPU_BREAKPOINT_EN
  // run_first_q masks the compare on the first RUN cycle so a run press can
  // leave a breakpoint the core is parked on.
  logic run_first_q;
  logic bp_hit_q;

  assign bp_stop = (state_q == ST_RUN) && bp_valid && (pc == bp_addr) && !run_first_q;
  assign bp_hit  = bp_hit_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      run_first_q <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      run_first_q <= (state_q == ST_PAUSE) && (state_d == ST_RUN);
      if ((state_q == ST_PAUSE) && (state_d == ST_RUN)) begin
        bp_hit_q <= 1'b0;
      end else if (bp_stop && (state_d == ST_PAUSE)) begin
        bp_hit_q <= 1'b1;
      end
    end
  end
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{pc, bp_addr, bp_valid};
  assign bp_stop          = 1'b0;
  assign bp_hit           = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; finish outranks every other exit from STEP/RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (hold_cnt == HOLD_LAST) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (run_press)       state_d = ST_RUN;
        else if (step_press) state_d = ST_STEP;
      end
      ST_STEP: begin
        if (finish)                 state_d = ST_DONE;
        else if (step_left == 8'd1) state_d = ST_PAUSE;
      end
      ST_RUN: begin
        if (finish)                    state_d = ST_DONE;
        else if (bp_stop || run_press) state_d = ST_PAUSE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_INIT;
    endcase
  end

  // Output decode from the registered state (plus breakpoint mask).
  always_comb begin
    cpu_rst = 1'b0;
    cpu_en  = 1'b0;
    case (state_q)
      ST_INIT: cpu_rst = 1'b1;
      ST_STEP: cpu_en  = 1'b1;
      ST_RUN:  cpu_en  = !bp_stop;
      default: begin
        cpu_rst = 1'b0;
        cpu_en  = 1'b0;
      end
    endcase
  end

  assign state = state_q;

  // Reset-hold, step window and statistics counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt   <= '0;
      step_left  <= 8'd0;
      step_count <= 16'd0;
      en_cycles  <= 32'd0;
    end else begin
      if ((state_q == ST_INIT) && (hold_cnt != HOLD_LAST)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (cpu_en) begin
        en_cycles <= en_cycles + 32'd1;
      end
      if ((state_q == ST_PAUSE) && (state_d == ST_STEP)) begin
        step_left  <= STEP_LOAD;
        step_count <= step_count + 16'd1;
      end else if (state_q == ST_STEP) begin
        step_left <= step_left - 8'd1;
      end
    end
  end

endmodule
